// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issues mul/div start pulses, stalls the pipe and requests write-back of the result or status
module multdiv_sequencer #(
  parameter int LATENCY    = 32,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 7,
  parameter int MUL_STATUS = 4,
  parameter int DIV_STATUS = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        x_valid,
  input  logic        flush,
  input  logic        op_r,
  input  logic [4:0]  func_code,
  input  logic [4:0]  x_rd,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  input  logic        wb_ack,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);
  if (TIMEOUT <= LATENCY || TIMEOUT >= (1 << CNT_W)) begin : g_bad_params
    $error("multdiv_sequencer: TIMEOUT must exceed LATENCY and fit in CNT_W bits");
  end
  typedef enum logic [1:0] {IDLE, START, RUN, WB} state_t;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic [4:0]       rd;
  logic             detect;
  logic             timed_out;
  logic             done;
  logic             exc;
  assign detect    = state == IDLE && x_valid && !flush && op_r && (func_code == 5'd6 || func_code == 5'd7);
  assign timed_out = cnt == CNT_W'(TIMEOUT - 1);
  assign done      = md_resultRDY || timed_out;
  assign exc       = md_resultRDY ? md_exception : 1'b1;
  assign ctrl_MULT = state == START && !is_div;
  assign ctrl_DIV  = state == START && is_div;
  assign busy      = state != IDLE;
  assign stall     = detect || busy;
  assign wb_valid  = state == WB;
  // next state: a clean result to $r0 skips write-back entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = detect ? START : IDLE;
      START:   state_nxt = RUN;
      RUN:     state_nxt = !done ? RUN : (exc || rd != 5'd0) ? WB : IDLE;
      default: state_nxt = wb_ack ? IDLE : WB;
    endcase
  end
  // state register; reset abandons any op in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end
  // op latch, run counter and write-back payload captured on leaving RUN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      rd      <= 5'd0;
      wb_rd   <= 5'd0;
      wb_data <= 32'd0;
    end else begin
      if (detect) begin
        is_div <= func_code == 5'd7;
        rd     <= x_rd;
      end
      if (state == START) cnt <= '0;
      else if (state == RUN) cnt <= cnt + CNT_W'(1);
      if (state == RUN && done) begin
        wb_rd   <= exc ? 5'd30 : rd;
        wb_data <= exc ? (is_div ? 32'(DIV_STATUS) : 32'(MUL_STATUS)) : md_result;
      end
    end
  end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: table-driven mul/div sequencing vectors plus reset and flush corner sequences
module tb_multdiv_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        x_valid = 1'b0, flush = 1'b0, op_r = 1'b0;
  logic [4:0]  func_code = 5'd0, x_rd = 5'd0;
  logic        md_resultRDY = 1'b0, md_exception = 1'b0;
  logic [31:0] md_result = 32'd0;
  logic        wb_ack = 1'b0;
  logic        ctrl_MULT, ctrl_DIV, stall, busy, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int checks = 0, errors = 0;
  int pulses = 0;
  logic both_seen = 1'b0;

  multdiv_sequencer dut (
    .clock(clock), .reset(reset), .x_valid(x_valid), .flush(flush), .op_r(op_r),
    .func_code(func_code), .x_rd(x_rd), .md_resultRDY(md_resultRDY),
    .md_exception(md_exception), .md_result(md_result), .wb_ack(wb_ack),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .stall(stall), .busy(busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    pulses += int'(ctrl_MULT) + int'(ctrl_DIV);
    if (ctrl_MULT && ctrl_DIV) both_seen = 1'b1;
  end

  typedef struct {
    logic        is_div;
    logic [4:0]  rd;
    logic        exc;
    logic [31:0] res;
    int          rdy_at;
    int          ack_wait;
    int          exp_run;
    int          exp_wb;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int run_cycles = 0;
    int wb_cycles = 0;
    int p0;
    logic stall_gap = 1'b0;
    p0 = pulses;
    x_valid = 1'b1; op_r = 1'b1; func_code = v.is_div ? 5'd7 : 5'd6; x_rd = v.rd;
    #1;
    chk($sformatf("v%0d detect stall", idx), stall, 1);
    chk($sformatf("v%0d detect busy", idx), busy, 0);
    tick();
    x_valid = 1'b0; func_code = 5'd0; x_rd = 5'd0;
    chk($sformatf("v%0d start mult", idx), ctrl_MULT, !v.is_div);
    chk($sformatf("v%0d start div", idx), ctrl_DIV, v.is_div);
    if (!stall) stall_gap = 1'b1;
    tick();
    while (busy && !wb_valid && run_cycles < 200) begin
      run_cycles++;
      if (!stall || ctrl_MULT || ctrl_DIV) stall_gap = 1'b1;
      if (run_cycles == v.rdy_at) begin
        md_resultRDY = 1'b1; md_exception = v.exc; md_result = v.res;
      end
      tick();
      md_resultRDY = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    end
    chk($sformatf("v%0d run cycles", idx), run_cycles, v.exp_run);
    while (wb_valid && wb_cycles < 20) begin
      wb_cycles++;
      chk($sformatf("v%0d wb_rd", idx), wb_rd, v.exp_rd);
      chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_data);
      if (!stall) stall_gap = 1'b1;
      wb_ack = wb_cycles > v.ack_wait;
      tick();
      wb_ack = 1'b0;
    end
    chk($sformatf("v%0d wb cycles", idx), wb_cycles, v.exp_wb);
    chk($sformatf("v%0d stall held", idx), stall_gap, 0);
    chk($sformatf("v%0d start pulses", idx), pulses - p0, 1);
    chk($sformatf("v%0d idle busy", idx), busy, 0);
    chk($sformatf("v%0d idle stall", idx), stall, 0);
  endtask

  initial begin
    //           div  rd     exc   res            rdy ack run wb  exp_rd exp_data
    vecs[0] = '{1'b0, 5'd5,  1'b0, 32'h0000_0030, 32, 0,  32, 1, 5'd5,  32'h30};
    vecs[1] = '{1'b1, 5'd7,  1'b1, 32'h0000_dead, 10, 0,  10, 1, 5'd30, 32'd5};
    vecs[2] = '{1'b0, 5'd7,  1'b1, 32'h0000_dead, 10, 0,  10, 1, 5'd30, 32'd4};
    vecs[3] = '{1'b0, 5'd0,  1'b0, 32'h0000_0055, 5,  0,  5,  0, 5'd0,  32'd0};
    vecs[4] = '{1'b0, 5'd9,  1'b0, 32'h1234_5678, 3,  3,  3,  4, 5'd9,  32'h1234_5678};
    vecs[5] = '{1'b1, 5'd3,  1'b0, 32'h0,         0,  0,  64, 1, 5'd30, 32'd5};
    vecs[6] = '{1'b1, 5'd12, 1'b0, 32'hffff_fff0, 1,  1,  1,  2, 5'd12, 32'hffff_fff0};
    vecs[7] = '{1'b0, 5'd0,  1'b1, 32'h0,         2,  0,  2,  1, 5'd30, 32'd4};
    vecs[8] = '{1'b0, 5'd31, 1'b0, 32'h0,         0,  0,  64, 1, 5'd30, 32'd4};

    #2 reset = 1'b0;
    tick(); tick();
    chk("reset busy", busy, 0);
    chk("reset stall", stall, 0);
    chk("reset wb_valid", wb_valid, 0);
    chk("reset wb_rd", wb_rd, 0);
    chk("reset wb_data", wb_data, 0);
    chk("reset ctrl", {ctrl_MULT, ctrl_DIV}, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i]);
      tick();
    end

    // detect blocked by flush, non-R-type and other func codes
    x_valid = 1'b1; op_r = 1'b1; func_code = 5'd6; x_rd = 5'd4; flush = 1'b1;
    #1;
    chk("flush stall", stall, 0);
    tick();
    chk("flush busy", busy, 0);
    chk("flush ctrl", {ctrl_MULT, ctrl_DIV}, 0);
    flush = 1'b0; op_r = 1'b0;
    #1;
    chk("non-R stall", stall, 0);
    op_r = 1'b1; func_code = 5'd5;
    #1;
    chk("func5 stall", stall, 0);
    x_valid = 1'b0; func_code = 5'd0;
    md_resultRDY = 1'b1; md_exception = 1'b1;
    tick();
    md_resultRDY = 1'b0; md_exception = 1'b0;
    chk("rdy in idle busy", busy, 0);
    chk("rdy in idle wb_valid", wb_valid, 0);

    // reset mid-run; a result pulse during START is also ignored
    x_valid = 1'b1; op_r = 1'b1; func_code = 5'd6; x_rd = 5'd5;
    tick();
    x_valid = 1'b0; func_code = 5'd0; x_rd = 5'd0;
    md_resultRDY = 1'b1; md_exception = 1'b1;
    chk("rst seq start", ctrl_MULT, 1);
    tick();
    md_resultRDY = 1'b0; md_exception = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    chk("rst seq run busy", busy, 1);
    chk("rst seq run no wb", wb_valid, 0);
    reset = 1'b0;
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset stall", stall, 0);
    chk("mid reset wb_valid", wb_valid, 0);
    chk("mid reset wb_rd", wb_rd, 0);
    chk("mid reset wb_data", wb_data, 0);
    tick();
    reset = 1'b1;
    md_resultRDY = 1'b1; md_result = 32'h77;
    tick();
    md_resultRDY = 1'b0; md_result = 32'd0;
    tick();
    chk("post reset busy", busy, 0);
    chk("post reset wb_valid", wb_valid, 0);
    chk("ctrl never both", both_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Sequences the shared iterative multiply/divide unit for R-type mul (func_code 5'd6) and div (func_code 5'd7) instructions in the X stage.
- Detects the op and issues a one-cycle start pulse to the unit.
- Stalls the pipeline while the unit runs, then requests the register-file write port for the result or for the exception status write to $r30.
- Sits between the decode/control outputs (op_r, func_code) and the multdiv unit and write-back mux.

Parameters:
LATENCY, 32, nominal cycles from start pulse to md_resultRDY
TIMEOUT, 64, cycles in RUN without md_resultRDY before forced exception; must be greater than LATENCY
CNT_W, 7, counter width; must hold TIMEOUT
MUL_STATUS, 4, rstatus value written to $r30 on mul overflow
DIV_STATUS, 5, rstatus value written to $r30 on divide by zero or timeout during div

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
x_valid  input  1  X-stage instruction valid (not a bubble)
flush  input  1  X-stage instruction is being squashed this cycle
op_r  input  1  X-stage op is R-type
func_code  input  5  X-stage function code
x_rd  input  5  X-stage destination register
md_resultRDY  input  1  multdiv result valid (single-cycle pulse)
md_exception  input  1  multdiv exception, valid with md_resultRDY
md_result  input  32  multdiv result, valid with md_resultRDY
wb_ack  input  1  write port granted to this block this cycle
ctrl_MULT  output  1  one-cycle start pulse, multiply
ctrl_DIV  output  1  one-cycle start pulse, divide
stall  output  1  freeze PC, F/D and D/X latches
busy  output  1  state is not IDLE
wb_valid  output  1  write-back request
wb_rd  output  5  write-back register
wb_data  output  32  write-back data

Behaviour:
- detect = x_valid & ~flush & op_r & (func_code==6 | func_code==7), evaluated only in IDLE.
- States: IDLE, START, RUN, WB.
- Reset (reset==0, asynchronous): state IDLE, counter 0, ctrl_MULT/ctrl_DIV/wb_valid 0, wb_rd 0, wb_data 0, latched is_div/rd cleared. Reset mid-operation abandons the op; no write-back occurs.
- IDLE: on detect, latch is_div = (func_code==7) and rd = x_rd, then go to START. Otherwise stay in IDLE.
- START: drive ctrl_MULT (is_div==0) or ctrl_DIV (is_div==1) high for exactly this cycle. Clear the counter. Go to RUN.
- RUN: increment the counter each cycle.
  - On md_resultRDY: capture md_exception and md_result, then go to WB.
  - If the counter reaches TIMEOUT-1 without md_resultRDY: force exception=1, then go to WB.
  - md_resultRDY seen in IDLE, START or WB is ignored.
- WB, set on entry:
  - Exception: wb_rd = 30; wb_data = MUL_STATUS (mul) or DIV_STATUS (div), zero-extended to 32 bits.
  - No exception, rd != 0: wb_rd = rd; wb_data = result.
  - No exception, rd == 0: skip WB and go straight to IDLE, with no wb_valid pulse.
- WB handshake: wb_valid is held high with stable wb_rd/wb_data until a cycle with wb_ack==1. In that cycle, return to IDLE and drop wb_valid on the next edge. wb_ack outside WB is ignored.
- stall = detect | (state != IDLE). This is combinational so the detecting instruction is held in D/X. stall deasserts in the cycle after the ack'd WB cycle, when the pipeline advances past the mul/div.
- busy = (state != IDLE).
- A new mul/div cannot be accepted until IDLE. Back-to-back ops therefore issue at least START+RUN+WB+1 cycles apart.
- flush is ignored outside IDLE: an issued op always completes.
- ctrl_MULT and ctrl_DIV are never high together and never high outside START.

Test Plan:
- mul, x_rd=5, md_resultRDY after 32 RUN cycles with md_result=0x0000_0030, wb_ack held high -> one ctrl_MULT pulse; wb_valid one cycle with wb_rd=5, wb_data=0x30; stall high from detect through the WB cycle.
- div with md_exception=1 -> wb_rd=30, wb_data=5. The same scenario as a mul -> wb_data=4.
- mul with x_rd=0, no exception -> no wb_valid; return to IDLE the cycle after md_resultRDY.
- wb_ack held low for 3 WB cycles, then high -> wb_valid/wb_rd/wb_data stable for 4 cycles; stall remains high until the ack cycle completes.
- md_resultRDY never arrives on a div -> after TIMEOUT RUN cycles, WB with wb_rd=30, wb_data=5.
- Reset pulled low in RUN cycle 10 -> all outputs 0 and IDLE immediately; a later md_resultRDY is ignored. Separately, detect with flush=1 -> no START, stall low.
